scale_param_buf: RTL and testbench

Parametrised multi-bank buffer for per-channel scale/tail coefficients in the quantisation epilogue. Holds NUM_MODES independent single-port banks, one per layer mode. A streaming loader FSM fills a selected bank with auto-incrementing addresses. A pipelined read port returns coefficients to the requant datapath with a fixed 2-cycle latency.

---
 rtl/scale_buf_pkg.sv | 11 +
 rtl/scale_buf_sp_ram.sv | 25 ++
 rtl/scale_param_buf.sv | 173 +++++++++++++++++
 tb/tb_scale_param_buf.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_buf_pkg.sv
// Shared types and constants for the scale/tail coefficient buffer.
package scale_buf_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } load_state_e;

    localparam int RD_LAT = 2;

endpackage

// File: rtl/scale_buf_sp_ram.sv
// Inferred single-port RAM with a registered read port; a write cycle does not update dout.
module scale_buf_sp_ram #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int ADR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [ADR_W-1:0] adr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[adr] <= din;
            else    dout     <= mem[adr];
        end
    end

endmodule

// File: rtl/scale_param_buf.sv
// Multi-bank coefficient buffer: streaming bank loader plus a 2-cycle pipelined read port.
// Define SCALE_BUF_PARITY_EN to store even parity per word and add rd_parity_err.
module scale_param_buf
    import scale_buf_pkg::*;
#(
    parameter int NUM_MODES = 2,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADR_W     = $clog2(DEPTH),
    parameter int MODE_W    = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [MODE_W-1:0] load_mode,
    input  logic [ADR_W:0]    load_len,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [MODE_W-1:0] rd_mode,
    input  logic [ADR_W-1:0]  rd_adr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
`ifdef SCALE_BUF_PARITY_EN
    ,
    output logic              rd_parity_err
`endif
);

`ifdef SCALE_BUF_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    load_state_e       state_q;
    logic [ADR_W-1:0]  cnt_q;
    logic [MODE_W-1:0] mode_q;
    logic [ADR_W:0]    len_q;
    logic              busy_q, done_q, err_q;

    logic wr_fire, req_bad, last_word, rd_mode_ok;

    // Reads own the single port of a bank, so a load into the bank being read stalls.
    assign wr_ready   = (state_q == ST_LOAD) && !(rd_en && (rd_mode == mode_q));
    assign wr_fire    = wr_valid && wr_ready;
    assign req_bad    = ({1'b0, load_mode} >= (MODE_W+1)'(NUM_MODES))
                     || (load_len > (ADR_W+1)'(DEPTH));
    assign last_word  = ({1'b0, cnt_q} == (len_q - 1'b1));
    assign rd_mode_ok = ({1'b0, rd_mode} < (MODE_W+1)'(NUM_MODES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else if (load_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b1;
                            mode_q  <= load_mode;
                            len_q   <= load_len;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_fire) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign load_busy = busy_q;
    assign load_done = done_q;
    assign load_err  = err_q;

    logic [RAM_W-1:0] wr_word;
    logic [RAM_W-1:0] bank_dout [NUM_MODES];

`ifdef SCALE_BUF_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_bank
        logic rd_sel, wr_sel;
        assign rd_sel = rd_en && (rd_mode == MODE_W'(m));
        assign wr_sel = wr_fire && (mode_q == MODE_W'(m));

        scale_buf_sp_ram #(
            .WIDTH (RAM_W),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk  (clk),
            .en   (rd_sel || wr_sel),
            .we   (wr_sel),
            .adr  (rd_sel ? rd_adr : cnt_q),
            .din  (wr_word),
            .dout (bank_dout[m])
        );
    end

    // Read pipeline: stage 1 is the RAM register, stage 2 the output register.
    logic [RD_LAT-1:0] vld_q;
    logic [MODE_W-1:0] mode1_q;
    logic              mode_ok1_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [RAM_W-1:0]  sel_word;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_word = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode1_q == MODE_W'(m)) sel_word = bank_dout[m];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            mode1_q    <= '0;
            mode_ok1_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            vld_q <= {vld_q[RD_LAT-2:0], rd_en};
            if (rd_en) begin
                mode1_q    <= rd_mode;
                mode_ok1_q <= rd_mode_ok;
            end
            if (vld_q[0]) rd_data_q <= mode_ok1_q ? sel_word[DATA_W-1:0] : '0;
        end
    end

    assign rd_valid = vld_q[RD_LAT-1];
    assign rd_data  = rd_data_q;

`ifdef SCALE_BUF_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= vld_q[0] && mode_ok1_q && (^sel_word);
    end
    assign rd_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_scale_param_buf.sv
// Self-checking bench for scale_param_buf with a word-level reference model of banks, loader and read pipe.
module tb_scale_param_buf;

    localparam int NM    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MW    = 2;

    logic          clk, rst_n;
    logic          load_start;
    logic [MW-1:0] load_mode;
    logic [AW:0]   load_len;
    logic          load_busy, load_done, load_err;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_en;
    logic [MW-1:0] rd_mode;
    logic [AW-1:0] rd_adr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
`ifdef SCALE_BUF_PARITY_EN
    logic          rd_parity_err;
`endif

    scale_param_buf #(
        .NUM_MODES (NM),
        .DATA_W    (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_mode  (load_mode),
        .load_len   (load_len),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_en      (rd_en),
        .rd_mode    (rd_mode),
        .rd_adr     (rd_adr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
`ifdef SCALE_BUF_PARITY_EN
        ,
        .rd_parity_err (rd_parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: bank contents, words still to load, expected read pipe.
    logic [DW-1:0] mem_m [NM][DEPTH];
    bit            corrupt [NM][DEPTH];
    bit            m_loading;
    int            m_mode, m_len, m_cnt;
    bit            p1_v, p1_perr, exp_done, exp_err, exp_perr;
    logic [DW-1:0] p1_d, last_d;
    logic [DW-1:0] load_words [DEPTH];

    task automatic cycle();
        bit            exp_ready, hs, iss_v, iss_p, n_done, n_err;
        logic [DW-1:0] iss_d;
        #1;
        exp_ready = m_loading && !(rd_en && int'(rd_mode) == m_mode);
        check("wr_ready", wr_ready, exp_ready);
        hs     = exp_ready && wr_valid;
        n_done = 0;
        n_err  = 0;
        iss_v  = rd_en;
        iss_d  = '0;
        iss_p  = 0;
        if (rd_en && int'(rd_mode) < NM) begin
            iss_d = mem_m[int'(rd_mode)][int'(rd_adr)];
            iss_p = corrupt[int'(rd_mode)][int'(rd_adr)];
        end
        if (m_loading) begin
            if (hs) begin
                mem_m[m_mode][m_cnt]   = wr_data;
                corrupt[m_mode][m_cnt] = 0;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_loading = 0;
                    n_done    = 1;
                end
            end
        end else if (load_start) begin
            if (int'(load_mode) >= NM || int'(load_len) > DEPTH) n_err = 1;
            else if (load_len == '0) n_done = 1;
            else begin
                m_loading = 1;
                m_mode    = int'(load_mode);
                m_len     = int'(load_len);
                m_cnt     = 0;
            end
        end
        @(posedge clk);
        #1;
        if (p1_v) last_d = p1_d;
        exp_perr = p1_v && p1_perr;
        check("load_busy", load_busy, m_loading);
        check("load_done", load_done, n_done);
        check("load_err", load_err, n_err);
        check("rd_valid", rd_valid, p1_v);
        check("rd_data", rd_data, last_d);
`ifdef SCALE_BUF_PARITY_EN
        check("rd_parity_err", rd_parity_err, exp_perr);
`endif
        p1_v    = iss_v;
        p1_d    = iss_d;
        p1_perr = iss_p;
    endtask

    task automatic idle_inputs();
        load_start = 0; load_mode = '0; load_len = '0;
        wr_valid = 0; wr_data = '0;
        rd_en = 0; rd_mode = '0; rd_adr = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        check("rst_busy", load_busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        m_loading = 0; m_cnt = 0;
        p1_v = 0; p1_perr = 0; last_d = '0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic do_load(input int mode, input int len, input int cs, input int cn);
        load_start = 1; load_mode = MW'(mode); load_len = (AW+1)'(len);
        rd_en = 0; wr_valid = 0;
        cycle();
        for (int k = 0; k < 200 && m_loading; k++) begin
            load_start = (k == 1);
            load_len   = (AW+1)'(DEPTH + 1);
            wr_valid   = 1;
            wr_data    = load_words[m_cnt];
            rd_en      = (k >= cs && k < cs + cn);
            rd_mode    = MW'(mode);
            rd_adr     = '0;
            cycle();
        end
        check("load_finished", m_loading, 0);
        idle_inputs();
        cycle();
    endtask

    task automatic read(input int mode, input int adr);
        rd_en = 1; rd_mode = MW'(mode); rd_adr = AW'(adr);
        cycle();
        rd_en = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        m_loading = 0;
        p1_v = 0; p1_perr = 0; last_d = '0;
        for (int b = 0; b < NM; b++)
            for (int a = 0; a < DEPTH; a++) corrupt[b][a] = 0;
        #12;
        do_reset();
        cycle();

        // Basic load of mode 1 with 0xA0..0xA3, then back-to-back reads.
        for (int i = 0; i < 4; i++) load_words[i] = DW'(32'hA0 + i);
        do_load(1, 4, 0, 0);
        for (int i = 0; i < 4; i++) read(1, i);
        cycle(); cycle();

        // Mode isolation at address 5.
        for (int i = 0; i < DEPTH; i++) load_words[i] = $urandom;
        load_words[5] = 32'h11;
        do_load(0, 6, 0, 0);
        load_words[5] = 32'h22;
        do_load(1, 6, 0, 0);
        for (int i = 0; i < 6; i++) read(i % 2, 5);
        cycle(); cycle();

        // Collision: three read cycles to the bank being loaded.
        for (int i = 0; i < DEPTH; i++) load_words[i] = $urandom;
        do_load(0, 6, 2, 3);
        for (int i = 0; i < 6; i++) read(0, i);
        cycle(); cycle();

        // Bad requests.
        load_start = 1; load_mode = 2'd0; load_len = (AW+1)'(DEPTH + 1);
        cycle();
        load_start = 1; load_mode = 2'd3; load_len = 5'd4;
        cycle();
        load_start = 1; load_mode = 2'd1; load_len = 5'd0;
        cycle();
        load_start = 0;
        cycle();
        read(3, 5);
        cycle(); cycle();

        // Reset after two of eight words into mode 2.
        for (int i = 0; i < DEPTH; i++) load_words[i] = $urandom;
        load_start = 1; load_mode = 2'd2; load_len = 5'd8;
        cycle();
        load_start = 0;
        for (int k = 0; k < 20 && m_cnt < 2; k++) begin
            wr_valid = 1; wr_data = load_words[m_cnt];
            cycle();
        end
        do_reset();
        cycle();
        read(2, 0);
        read(2, 1);
        cycle(); cycle();

        // Fill every bank, then random traffic.
        for (int b = 0; b < NM; b++) begin
            for (int i = 0; i < DEPTH; i++) load_words[i] = $urandom;
            do_load(b, DEPTH, 0, 0);
        end
        for (int n = 0; n < 300; n++) begin
            load_start = ($urandom_range(0, 7) == 0);
            load_mode  = MW'($urandom_range(0, 3));
            load_len   = (AW+1)'($urandom_range(0, DEPTH + 1));
            wr_valid   = 1'($urandom);
            wr_data    = $urandom;
            rd_en      = 1'($urandom);
            rd_mode    = MW'($urandom_range(0, 3));
            rd_adr     = AW'($urandom);
            cycle();
        end
        idle_inputs();
        for (int k = 0; k < 40 && m_loading; k++) begin
            wr_valid = 1; wr_data = $urandom;
            cycle();
        end
        idle_inputs();
        cycle(); cycle();

`ifdef SCALE_BUF_PARITY_EN
        dut.g_bank[1].u_ram.mem[3][DW] = ~dut.g_bank[1].u_ram.mem[3][DW];
        corrupt[1][3] = 1;
        read(1, 2);
        read(1, 3);
        read(1, 4);
        read(3, 3);
        cycle(); cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
